// File: rtl/flit_packetizer_pkg.sv
// Shared widths, flit type codes, head-flit field layout and FSM state type
// for the spidergon local-port flit packetizer.
package flit_packetizer_pkg;

    localparam int NUM_OF_NODES            = 8;
    localparam int DEST_NODE_WIDTH         = $clog2(NUM_OF_NODES);
    localparam int FLIT_DATA_WIDTH         = 16;
    localparam int NUM_OF_VIRTUAL_CHANNELS = 2;
    localparam int VC_WIDTH                = $clog2(NUM_OF_VIRTUAL_CHANNELS);
    localparam int VC_CREDITS              = 2;
    localparam int CREDIT_WIDTH            = $clog2(VC_CREDITS + 1);
    localparam int MAX_PAYLOAD_FLITS       = 4;
    localparam int LEN_WIDTH               = $clog2(MAX_PAYLOAD_FLITS + 1);
    localparam int HEAD_TAIL               = 2;
    localparam int FLIT_TOTAL_WIDTH        = HEAD_TAIL + VC_WIDTH + FLIT_DATA_WIDTH;

    localparam logic [HEAD_TAIL-1:0] HEAD_FLIT = 2'b01;
    localparam logic [HEAD_TAIL-1:0] BODY_FLIT = 2'b10;
    localparam logic [HEAD_TAIL-1:0] TAIL_FLIT = 2'b00;
    localparam logic [HEAD_TAIL-1:0] HEADER    = 2'b11;

    // Head payload: destination in the top bits, source just below, rest zero.
    localparam int HEAD_DEST_LSB = FLIT_DATA_WIDTH - DEST_NODE_WIDTH;
    localparam int HEAD_SRC_LSB  = HEAD_DEST_LSB - DEST_NODE_WIDTH;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        VC_SEL = 2'd1,
        DATA   = 2'd2
    } state_t;

    function automatic logic [FLIT_DATA_WIDTH-1:0] head_payload(
        input logic [DEST_NODE_WIDTH-1:0] dest,
        input logic [DEST_NODE_WIDTH-1:0] src
    );
        return {dest, src, {HEAD_SRC_LSB{1'b0}}};
    endfunction

endpackage

// File: rtl/flit_packetizer_if.sv
// Message-in / flit-out / credit-return bundle of the packetizer.
// Handshakes: a message transfers on a cycle with pkt_valid & pkt_ready high;
// flit_out is consumed by the router whenever flit_valid is high (credit
// already guaranteed); each credit_return bit is a one-cycle pulse per freed slot.
interface flit_packetizer_if;
    import flit_packetizer_pkg::*;

    logic                                         pkt_valid;
    logic                                         pkt_ready;
    logic [DEST_NODE_WIDTH-1:0]                   pkt_dest;
    logic [LEN_WIDTH-1:0]                         pkt_len;
    logic [MAX_PAYLOAD_FLITS*FLIT_DATA_WIDTH-1:0] pkt_data;
    logic [FLIT_TOTAL_WIDTH-1:0]                  flit_out;
    logic                                         flit_valid;
    logic [NUM_OF_VIRTUAL_CHANNELS-1:0]           credit_return;
    logic                                         pkt_done;

    modport master (
        output pkt_valid, pkt_dest, pkt_len, pkt_data, credit_return,
        input  pkt_ready, flit_out, flit_valid, pkt_done
    );

    modport slave (
        input  pkt_valid, pkt_dest, pkt_len, pkt_data, credit_return,
        output pkt_ready, flit_out, flit_valid, pkt_done
    );

endinterface

// File: rtl/flit_packetizer_vc_credit_counter.sv
// Per-VC credit counter: decrements on a sent flit, increments on a returned
// slot, holds when both happen together, saturates at VC_CREDITS.
module vc_credit_counter
    import flit_packetizer_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    dec,
    input  logic                    inc,
    output logic [CREDIT_WIDTH-1:0] count,
    output logic                    has_credit
);

    localparam logic [CREDIT_WIDTH-1:0] FULL = CREDIT_WIDTH'(VC_CREDITS);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= FULL;
        end else if (dec && !inc) begin
            count <= count - CREDIT_WIDTH'(1);
        end else if (inc && !dec && count != FULL) begin
            count <= count + CREDIT_WIDTH'(1);
        end
    end

    assign has_credit = (count != '0);

`ifdef FORMAL
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(inc && !dec && count == FULL));
            assert (!(dec && count == '0));
        end
    end
`endif

endmodule

// File: rtl/flit_packetizer.sv
// Serialises one message into HEAD/BODY/TAIL (or a single HEADER) flit stream
// under per-VC credit flow control. `define VC_ROUND_ROBIN_EN for round-robin VC choice.
module flit_packetizer
    import flit_packetizer_pkg::*;
#(
    parameter int NODE_ID = 0
) (
    input  logic                                           clk,
    input  logic                                           reset,
    flit_packetizer_if.slave                               bus,
    output state_t                                         state_dbg,
    output logic [NUM_OF_VIRTUAL_CHANNELS*CREDIT_WIDTH-1:0] credit_dbg
);

    localparam int NV = NUM_OF_VIRTUAL_CHANNELS;
    localparam logic [DEST_NODE_WIDTH-1:0] SRC_ID = DEST_NODE_WIDTH'(NODE_ID);

    state_t                                       state_q, state_d;
    logic [DEST_NODE_WIDTH-1:0]                   dest_q;
    logic [LEN_WIDTH-1:0]                         len_q, len_clamped, idx_q;
    logic [MAX_PAYLOAD_FLITS*FLIT_DATA_WIDTH-1:0] data_q;
    logic [VC_WIDTH-1:0]                          vc_q, sel_vc, cur_vc;
    logic [NV-1:0]                                has_credit, dec;
    logic [CREDIT_WIDTH-1:0]                      credit [NV];
    logic                                         any_credit, last_word, accept;
    logic                                         send, pkt_ready_c, pkt_done_c;
    logic [HEAD_TAIL-1:0]                         flit_type;
    logic [FLIT_DATA_WIDTH-1:0]                   payload, word;
`ifdef VC_ROUND_ROBIN_EN
    logic [VC_WIDTH-1:0]                          rr_ptr_q;
`endif

    assign len_clamped = (bus.pkt_len > LEN_WIDTH'(MAX_PAYLOAD_FLITS))
                       ? LEN_WIDTH'(MAX_PAYLOAD_FLITS) : bus.pkt_len;
    assign accept    = bus.pkt_valid && pkt_ready_c;
    assign last_word = (idx_q == len_q - LEN_WIDTH'(1));
    assign word      = data_q[idx_q*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
    assign cur_vc    = (state_q == VC_SEL) ? sel_vc : vc_q;

    // VC choice only matters in VC_SEL; afterwards the packet stays on vc_q.
    always_comb begin
        sel_vc     = '0;
        any_credit = 1'b0;
`ifdef VC_ROUND_ROBIN_EN
        for (int i = 1; i <= NV; i++) begin
            int j;
            j = (int'(rr_ptr_q) + i) % NV;
            if (!any_credit && has_credit[VC_WIDTH'(j)]) begin
                any_credit = 1'b1;
                sel_vc     = VC_WIDTH'(j);
            end
        end
`else
        for (int i = NV - 1; i >= 0; i--) begin
            if (has_credit[VC_WIDTH'(i)]) begin
                any_credit = 1'b1;
                sel_vc     = VC_WIDTH'(i);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.pkt_valid) state_d = VC_SEL;
            VC_SEL:  if (any_credit) state_d = (len_q == '0) ? IDLE : DATA;
            DATA:    if (has_credit[vc_q] && last_word) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        send        = 1'b0;
        pkt_ready_c = 1'b0;
        pkt_done_c  = 1'b0;
        flit_type   = TAIL_FLIT;
        payload     = '0;
        case (state_q)
            IDLE: pkt_ready_c = 1'b1;
            VC_SEL: begin
                send       = any_credit;
                flit_type  = (len_q == '0) ? HEADER : HEAD_FLIT;
                payload    = head_payload(dest_q, SRC_ID);
                pkt_done_c = any_credit && (len_q == '0);
            end
            DATA: begin
                send       = has_credit[vc_q];
                flit_type  = last_word ? TAIL_FLIT : BODY_FLIT;
                payload    = word;
                pkt_done_c = has_credit[vc_q] && last_word;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dest_q   <= '0;
            len_q    <= '0;
            data_q   <= '0;
            vc_q     <= '0;
            idx_q    <= '0;
`ifdef VC_ROUND_ROBIN_EN
            rr_ptr_q <= VC_WIDTH'(NV - 1);
`endif
        end else begin
            if (accept) begin
                dest_q <= bus.pkt_dest;
                len_q  <= len_clamped;
                data_q <= bus.pkt_data;
            end
            if (state_q == VC_SEL && send) begin
                vc_q     <= sel_vc;
                idx_q    <= '0;
`ifdef VC_ROUND_ROBIN_EN
                rr_ptr_q <= sel_vc;
`endif
            end else if (state_q == DATA && send) begin
                idx_q <= idx_q + LEN_WIDTH'(1);
            end
        end
    end

    for (genvar v = 0; v < NV; v++) begin : g_vc
        assign dec[v] = send && (cur_vc == VC_WIDTH'(v));
        vc_credit_counter u_cnt (
            .clk        (clk),
            .reset      (reset),
            .dec        (dec[v]),
            .inc        (bus.credit_return[v]),
            .count      (credit[v]),
            .has_credit (has_credit[v])
        );
        assign credit_dbg[v*CREDIT_WIDTH +: CREDIT_WIDTH] = credit[v];
    end

    assign bus.pkt_ready  = pkt_ready_c;
    assign bus.flit_valid = send;
    assign bus.flit_out   = send ? {flit_type, cur_vc, payload} : '0;
    assign bus.pkt_done   = pkt_done_c;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Bench for flit_packetizer: queue-based packet model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_flit_packetizer;
  import flit_packetizer_pkg::*;

  localparam int NV = NUM_OF_VIRTUAL_CHANNELS;
  localparam int DW = DEST_NODE_WIDTH;
  localparam int FDW = FLIT_DATA_WIDTH;
  localparam int TB_NODE = 1;

  typedef struct packed {
    logic [1:0]     t;
    logic [FDW-1:0] p;
  } mflit_t;

  logic clk = 1'b0;
  logic reset;
  state_t state_dbg;
  logic [NV*CREDIT_WIDTH-1:0] credit_dbg;
  logic [NV-1:0] dir_ret, rnd_ret;
  bit rnd_en;

  int vecs = 0;
  int errs = 0;

  flit_packetizer_if bus ();
  assign bus.credit_return = dir_ret | rnd_ret;

  flit_packetizer #(.NODE_ID(TB_NODE)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state_dbg  (state_dbg),
    .credit_dbg (credit_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // behavioural model: pending flits of the accepted packet plus credit ledger
  mflit_t pend[$];
  int locked = -1;
  int last_vc = NV - 1;
  int mcred[NV];
  bit model_on = 1'b0;
  bit e_ready, e_valid, e_done, accepting;
  int e_vc;
  logic [FLIT_TOTAL_WIDTH-1:0] e_flit;
  logic [NV*CREDIT_WIDTH-1:0] e_cred;

  function automatic int pick_vc();
`ifdef VC_ROUND_ROBIN_EN
    for (int i = 1; i <= NV; i++) begin
      if (mcred[(last_vc + i) % NV] > 0) return (last_vc + i) % NV;
    end
`else
    for (int v = 0; v < NV; v++) begin
      if (mcred[v] > 0) return v;
    end
`endif
    return -1;
  endfunction

  task automatic build(input logic [DW-1:0] d, input logic [LEN_WIDTH-1:0] len_in,
                       input logic [MAX_PAYLOAD_FLITS*FDW-1:0] data);
    int l;
    logic [FDW-1:0] hp;
    l = (int'(len_in) > MAX_PAYLOAD_FLITS) ? MAX_PAYLOAD_FLITS : int'(len_in);
    hp = {d, DW'(TB_NODE), {(FDW-2*DW){1'b0}}};
    pend.push_back('{t: (l == 0) ? 2'b11 : 2'b01, p: hp});
    for (int i = 0; i < l; i++)
      pend.push_back('{t: (i == l - 1) ? 2'b00 : 2'b10, p: data[i*FDW +: FDW]});
  endtask

  always begin
    @(negedge clk);
    e_ready = (pend.size() == 0);
    e_valid = 1'b0;
    e_done  = 1'b0;
    e_flit  = '0;
    e_vc    = -1;
    if (pend.size() != 0) begin
      e_vc    = (locked < 0) ? pick_vc() : locked;
      e_valid = (e_vc >= 0) && (mcred[e_vc] > 0);
      if (e_valid) begin
        e_flit = {pend[0].t, VC_WIDTH'(e_vc), pend[0].p};
        e_done = (pend.size() == 1);
      end
    end
    for (int v = 0; v < NV; v++) e_cred[v*CREDIT_WIDTH +: CREDIT_WIDTH] = CREDIT_WIDTH'(mcred[v]);
    if (model_on && !reset) begin
      check("flit_valid", 32'(bus.flit_valid), 32'(e_valid));
      check("flit_out", 32'(bus.flit_out), 32'(e_flit));
      check("pkt_done", 32'(bus.pkt_done), 32'(e_done));
      check("pkt_ready", 32'(bus.pkt_ready), 32'(e_ready));
      check("state_idle", 32'(state_dbg == IDLE), 32'(e_ready));
      check("credits", 32'(credit_dbg), 32'(e_cred));
    end
    @(posedge clk);
    if (reset) begin
      pend.delete();
      locked   = -1;
      last_vc  = NV - 1;
      for (int v = 0; v < NV; v++) mcred[v] = VC_CREDITS;
      model_on = 1'b1;
    end else if (model_on) begin
      accepting = e_ready && bus.pkt_valid;
      for (int v = 0; v < NV; v++) begin
        mcred[v] = mcred[v] - ((e_valid && e_vc == v) ? 1 : 0) + (bus.credit_return[v] ? 1 : 0);
        if (mcred[v] > VC_CREDITS) mcred[v] = VC_CREDITS;
      end
      if (e_valid) begin
        if (locked < 0) begin
          locked  = e_vc;
          last_vc = e_vc;
        end
        void'(pend.pop_front());
        if (pend.size() == 0) locked = -1;
      end
      if (accepting) build(bus.pkt_dest, bus.pkt_len, bus.pkt_data);
    end
  end

  // random credit returns, only where a slot is actually outstanding
  always begin
    @(posedge clk);
    #1;
    rnd_ret = '0;
    if (rnd_en)
      for (int v = 0; v < NV; v++)
        if (mcred[v] < VC_CREDITS && $urandom_range(0, 1) == 1) rnd_ret[v] = 1'b1;
  end

  // driver tasks (entered and left just after a rising edge)
  task automatic send_pkt(input logic [DW-1:0] d, input logic [LEN_WIDTH-1:0] l,
                          input logic [MAX_PAYLOAD_FLITS*FDW-1:0] data);
    int n = 0;
    bus.pkt_valid = 1'b1;
    bus.pkt_dest  = d;
    bus.pkt_len   = l;
    bus.pkt_data  = data;
    forever begin
      @(negedge clk);
      if (bus.pkt_ready) break;
      n++;
      if (n > 500) begin
        check("accept_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.pkt_valid = 1'b0;
    bus.pkt_dest  = DW'($urandom);
    bus.pkt_len   = LEN_WIDTH'($urandom);
    bus.pkt_data  = {$urandom, $urandom};
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge clk);
      if (pend.size() == 0) break;
      n++;
      if (n > 500) begin
        check("idle_timeout", 32'(n), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    int rr_exp[3];
    logic [MAX_PAYLOAD_FLITS*FDW-1:0] d4;
`ifdef VC_ROUND_ROBIN_EN
    rr_exp = '{0, 1, 0};
`else
    rr_exp = '{0, 0, 0};
`endif
    bus.pkt_valid = 1'b0;
    bus.pkt_dest  = '0;
    bus.pkt_len   = '0;
    bus.pkt_data  = '0;
    dir_ret = '0;
    rnd_ret = '0;
    rnd_en  = 1'b0;
    reset   = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(bus.pkt_ready), 32'd1);
    check("rst_valid", 32'(bus.flit_valid), 32'd0);
    check("rst_flit", 32'(bus.flit_out), 32'd0);
    check("rst_credits", 32'(credit_dbg), 32'b1010);
    tick();

    // single HEADER flit
    send_pkt(3'd3, 3'd0, '0);
    @(negedge clk);
    check("hdr_flit", 32'(bus.flit_out), 32'h66400);
    check("hdr_done", 32'(bus.pkt_done), 32'd1);
    tick();
    @(negedge clk);
    check("hdr_vc0_credit", 32'(credit_dbg[1:0]), 32'd1);
    tick();

    // L=3 with credit stall and single returns
    apply_reset();
    send_pkt(3'd5, 3'd3, {16'h0, 16'h00C3, 16'h00B2, 16'h00A1});
    @(negedge clk);
    check("l3_head", 32'(bus.flit_out), 32'h2A400);
    tick();
    @(negedge clk);
    check("l3_body0", 32'(bus.flit_out), 32'h400A1);
    tick();
    @(negedge clk);
    check("l3_stall", 32'(bus.flit_valid), 32'd0);
    tick();
    dir_ret = 2'b01;
    tick();
    dir_ret = 2'b00;
    @(negedge clk);
    check("l3_body1", 32'(bus.flit_out), 32'h400B2);
    tick();
    dir_ret = 2'b01;
    tick();
    dir_ret = 2'b00;
    @(negedge clk);
    check("l3_tail", 32'(bus.flit_out), 32'h000C3);
    check("l3_done", 32'(bus.pkt_done), 32'd1);
    tick();

    // VC0 exhausted -> next packet goes to VC1
    apply_reset();
    send_pkt(3'd2, 3'd1, 64'h1111);
    wait_idle();
    send_pkt(3'd6, 3'd1, 64'h2222);
    @(negedge clk);
    check("vc1_head_vc", 32'(bus.flit_out[FDW +: VC_WIDTH]), 32'd1);
    check("vc1_vc0_untouched", 32'(credit_dbg[1:0]), 32'd0);
    wait_idle();

    // simultaneous send and return holds the counter
    apply_reset();
    d4 = {$urandom, $urandom};
    send_pkt(3'd1, 3'd4, d4);
    tick();
    for (int k = 0; k < 4; k++) begin
      dir_ret = 2'b01;
      @(negedge clk);
      check("hold_valid", 32'(bus.flit_valid), 32'd1);
      check("hold_credit", 32'(credit_dbg[1:0]), 32'd1);
      tick();
    end
    dir_ret = 2'b00;
    wait_idle();

    // reset during the second BODY flit
    apply_reset();
    d4 = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    send_pkt(3'd7, 3'd4, d4);
    dir_ret = 2'b01;
    tick();
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("mid_body1", 32'(bus.flit_out), 32'h42222);
    tick();
    reset   = 1'b0;
    dir_ret = 2'b00;
    @(negedge clk);
    check("mid_rst_valid", 32'(bus.flit_valid), 32'd0);
    check("mid_rst_ready", 32'(bus.pkt_ready), 32'd1);
    check("mid_rst_credits", 32'(credit_dbg), 32'b1010);
    tick();
    send_pkt(3'd3, 3'd0, '0);
    @(negedge clk);
    check("mid_clean_hdr", 32'(bus.flit_out), 32'h66400);
    tick();

    // VC selection order over three HEADER packets
    apply_reset();
    for (int k = 0; k < 3; k++) begin
      int vc;
      send_pkt(3'd4, 3'd0, '0);
      @(negedge clk);
      vc = int'(bus.flit_out[FDW +: VC_WIDTH]);
      check("vc_order", 32'(vc), 32'(rr_exp[k]));
      tick();
      dir_ret = '0;
      dir_ret[VC_WIDTH'(vc)] = 1'b1;
      tick();
      dir_ret = '0;
    end

    // randomized traffic, lengths include values above MAX to exercise clamping
    rnd_en = 1'b1;
    for (int k = 0; k < 250; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      send_pkt(DW'($urandom), LEN_WIDTH'($urandom_range(0, 7)), {$urandom, $urandom});
    end
    wait_idle();
    rnd_en = 1'b0;
    repeat (4) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/flit_packetizer.md
Name: flit_packetizer

Overview:
- Per-node network-interface injector that sits directly upstream of one spidergon node's local input port.
- Accepts a message (destination plus up to MAX_PAYLOAD_FLITS data words) over a valid/ready handshake.
- Serialises the message into HEAD/BODY/TAIL flits, or a single HEADER flit.
- Drives those flits into the router's local port under per-VC credit flow control; each VC buffer holds 2 flits.

Parameters:
- NUM_OF_NODES, 8, ring size; DEST_NODE_WIDTH = $clog2(NUM_OF_NODES).
- FLIT_DATA_WIDTH, 16, flit payload width; must be >= 2*DEST_NODE_WIDTH.
- NUM_OF_VIRTUAL_CHANNELS, 2, VCs on the router local input port.
- VC_CREDITS, 2, flit slots per VC buffer (NODE_BUFFER_WIDTH/FLIT_DATA_WIDTH).
- MAX_PAYLOAD_FLITS, 4, maximum data flits per packet.
- NODE_ID, 0, source address placed in head flits.

Ports:
- clk, input, 1, clock.
- reset, input, 1, synchronous, active-high.
- pkt_valid, input, 1, message offered.
- pkt_ready, output, 1, block can accept a message.
- pkt_dest, input, DEST_NODE_WIDTH, destination node.
- pkt_len, input, $clog2(MAX_PAYLOAD_FLITS+1), number of payload flits L (0..MAX).
- pkt_data, input, MAX_PAYLOAD_FLITS*FLIT_DATA_WIDTH, word i at [i*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH].
- flit_out, output, FLIT_TOTAL_WIDTH = 2+$clog2(NUM_OF_VIRTUAL_CHANNELS)+FLIT_DATA_WIDTH, flit {type, vc, payload}.
- flit_valid, output, 1, flit_out valid this cycle.
- credit_return, input, NUM_OF_VIRTUAL_CHANNELS, one-cycle pulse per freed router slot.
- pkt_done, output, 1, pulse in the cycle the last flit of a packet is valid.

Behaviour:
- Flit type codes: HEAD=01, BODY=10, TAIL=00, HEADER=11 (single flit, no data).
- Head/header payload: {dest, NODE_ID, zeros}.
- Reset: state IDLE; pkt_ready=1; flit_valid=0; flit_out=0; pkt_done=0; every credit counter = VC_CREDITS.
- Handshake: a message is accepted when pkt_valid & pkt_ready. pkt_ready=1 only in IDLE. dest, len and data are registered on acceptance; later input changes are ignored.
- pkt_len > MAX_PAYLOAD_FLITS is clamped to MAX.
- FSM:
  - IDLE: on accept -> VC_SEL.
  - VC_SEL: pick a VC with credit > 0, lock it for the whole packet, emit HEADER (L=0, -> IDLE) or HEAD (L>=1, -> DATA). Stays in VC_SEL while no VC has credit.
  - DATA: emit words 0..L-2 as BODY, then word L-1 as TAIL, -> IDLE. One flit per cycle while the locked VC has credit; otherwise stall with flit_valid=0.
- Flit count: L=0 gives 1 flit; L>=1 gives L+1 flits.
- Latency: earliest first flit is registered and valid the cycle after acceptance. Back-to-back packets have one IDLE cycle between them.
- Credits, per VC:
  - send only: -1.
  - credit_return only: +1.
  - both in the same cycle: unchanged.
  - Never exceeds VC_CREDITS; a return at full credit is ignored (FORMAL assertion flags it).
  - Never underflows: a flit is sent only when credit > 0.
- pkt_done is high together with flit_valid on the TAIL or HEADER flit.
- Reset mid-packet: the partial packet is dropped, and the next cycle flit_valid=0 and state=IDLE.

Optional Feature:
- Macro VC_ROUND_ROBIN_EN.
- Defined: VC_SEL uses round-robin starting after the last-used VC. The pointer resets to VC NUM_OF_VIRTUAL_CHANNELS-1, so the first pick is VC0.
- Undefined: fixed priority, lowest-index VC with credit > 0.

Decomposition:
- Shared package/header holds:
  - flit type localparams (HEAD_FLIT, BODY_FLIT, TAIL_FLIT, HEADER);
  - HEAD_TAIL=2;
  - FLIT_TOTAL_WIDTH and DEST_NODE_WIDTH expressions;
  - the head-payload field layout.
- One sub-module: vc_credit_counter, a per-VC up/down saturating counter instantiated NUM_OF_VIRTUAL_CHANNELS times.

Test Plan:
- L=0, dest=3, NODE_ID=1 -> one flit 11_0_{3,1,0..}, pkt_done same cycle, VC0 credit 2->1.
- L=3, words 0xA1,0xB2,0xC3, dest=5 -> HEAD, BODY 0xA1, BODY 0xB2, TAIL 0xC3 on consecutive cycles, all vc=0, VC0 credit stalls after the 2nd flit. Then credit_return[0] pulses one at a time -> one flit per pulse; pkt_done on the TAIL.
- VC0 credit 0, VC1 credit 2, L=1 -> HEAD and TAIL on vc=1; VC0 untouched.
- Simultaneous send and credit_return on the locked VC for 4 cycles -> counter holds at 1, no stall.
- Reset asserted during the 2nd BODY of an L=4 packet -> next cycle flit_valid=0, pkt_ready=1, credits=2/2; the following packet starts clean.
- VC_ROUND_ROBIN_EN: three L=0 packets with credits replenished -> vc sequence 0,1,0. Without the macro -> 0,0,0.
